// File: rtl/net_resolver_pkg.sv
// Shared constants and the per-bit resolution function for the multi-driver net model.
// Drivers are packed into a MAX_DRIVERS-wide vector; unused positions are never enabled.
package net_resolver_pkg;

  localparam int MODE_TRI    = 0;
  localparam int MODE_WOR    = 1;
  localparam int MODE_WAND   = 2;
  localparam int MAX_DRIVERS = 32;

  typedef struct packed {
    logic val;
    logic z;
    logic conflict;
  } bit_res_t;

  // Undriven bits report val=0; the caller decides whether charge is held.
  function automatic bit_res_t resolve_bit(
    input int                     mode,
    input logic [MAX_DRIVERS-1:0] en_vec,
    input logic [MAX_DRIVERS-1:0] data_vec
  );
    bit_res_t r;
    logic     any_en;
    logic     any_one;
    logic     any_zero;
    any_en     = |en_vec;
    any_one    = |(en_vec & data_vec);
    any_zero   = |(en_vec & ~data_vec);
    r.z        = ~any_en;
    r.val      = 1'b0;
    r.conflict = 1'b0;
    case (mode)
      MODE_TRI: begin
        r.val      = any_one;
        r.conflict = any_one & any_zero;
      end
      MODE_WOR: begin
        r.val = any_one;
      end
      MODE_WAND: begin
        r.val = any_en & ~any_zero;
      end
      default: begin
        r.val      = 1'b0;
        r.conflict = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/net_resolver_lane.sv
// Combinational resolution of a single bit position across all driver channels.
module net_resolve_lane
  import net_resolver_pkg::*;
#(
  parameter int NUM_DRIVERS = 3,
  parameter int MODE        = MODE_WOR
) (
  input  logic [NUM_DRIVERS-1:0] en,
  input  logic [NUM_DRIVERS-1:0] data,
  output logic                   val,
  output logic                   z,
  output logic                   conflict
);

  logic [MAX_DRIVERS-1:0] en_pad_s;
  logic [MAX_DRIVERS-1:0] data_pad_s;
  bit_res_t               res_s;

  // Zero-extend the driver vectors and resolve the bit.
  always_comb begin
    en_pad_s                     = {MAX_DRIVERS{1'b0}};
    data_pad_s                   = {MAX_DRIVERS{1'b0}};
    en_pad_s[NUM_DRIVERS-1:0]    = en;
    data_pad_s[NUM_DRIVERS-1:0]  = data;
    res_s                        = resolve_bit(MODE, en_pad_s, data_pad_s);
  end

  assign val      = res_s.val;
  assign z        = res_s.z;
  assign conflict = res_s.conflict;

endmodule

// File: rtl/net_resolver.sv
// Registered multi-driver net resolver with per-bit z flags and contention statistics.
// All resolution is done by one net_resolve_lane per bit; this level only holds state.
module net_resolver
  import net_resolver_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_DRIVERS = 3,
  parameter int MODE        = 1,
  parameter int CHARGE_HOLD = 0,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [NUM_DRIVERS-1:0]       drv_en,
  input  logic [NUM_DRIVERS*WIDTH-1:0] drv_data,
  input  logic                         clear_stats,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [WIDTH-1:0]             out_z,
  output logic                         contention,
  output logic [CNT_W-1:0]             contention_count,
  output logic                         sticky_contention
);

  if (MODE > 2) begin : g_bad_mode
    $fatal(1, "net_resolver: illegal MODE %0d", MODE);
  end
  if ((NUM_DRIVERS < 1) || (NUM_DRIVERS > MAX_DRIVERS)) begin : g_bad_drivers
    $fatal(1, "net_resolver: NUM_DRIVERS %0d out of range", NUM_DRIVERS);
  end

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [WIDTH-1:0] res_val_s;
  logic [WIDTH-1:0] res_z_s;
  logic [WIDTH-1:0] conflict_s;
  logic             contention_s;
  logic [WIDTH-1:0] data_nxt_s;
  logic [CNT_W-1:0] count_base_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             sticky_base_s;
  logic             sticky_nxt_s;

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] z_r;
  logic             contention_r;
  logic [CNT_W-1:0] count_r;
  logic             sticky_r;

  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    logic [NUM_DRIVERS-1:0] lane_data_s;
    for (genvar i = 0; i < NUM_DRIVERS; i++) begin : g_drv
      assign lane_data_s[i] = drv_data[i*WIDTH + b];
    end
    net_resolve_lane #(
      .NUM_DRIVERS(NUM_DRIVERS),
      .MODE       (MODE)
    ) u_lane (
      .en      (drv_en),
      .data    (lane_data_s),
      .val     (res_val_s[b]),
      .z       (res_z_s[b]),
      .conflict(conflict_s[b])
    );
  end

  assign contention_s = |conflict_s;

  // Undriven bits either keep their charge or fall to 0.
  always_comb begin
    data_nxt_s = res_val_s;
    if (CHARGE_HOLD != 0) begin
      data_nxt_s = (res_val_s & ~res_z_s) | (data_r & res_z_s);
    end else begin
      data_nxt_s = res_val_s & ~res_z_s;
    end
  end

  // Statistics: a same-cycle clear is applied before this cycle's event is counted.
  always_comb begin
    count_base_s  = count_r;
    sticky_base_s = sticky_r;
    if (clear_stats) begin
      count_base_s  = CNT_ZERO;
      sticky_base_s = 1'b0;
    end else begin
      count_base_s  = count_r;
      sticky_base_s = sticky_r;
    end
    count_nxt_s  = count_base_s;
    sticky_nxt_s = sticky_base_s;
    if (in_valid && contention_s) begin
      sticky_nxt_s = 1'b1;
      if (count_base_s != CNT_MAX) begin
        count_nxt_s = count_base_s + CNT_ONE;
      end else begin
        count_nxt_s = count_base_s;
      end
    end else begin
      count_nxt_s  = count_base_s;
      sticky_nxt_s = sticky_base_s;
    end
  end

  // Output word, z flags and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r      <= 1'b0;
      data_r       <= {WIDTH{1'b0}};
      z_r          <= {WIDTH{1'b1}};
      contention_r <= 1'b0;
      count_r      <= CNT_ZERO;
      sticky_r     <= 1'b0;
    end else begin
      valid_r  <= in_valid;
      count_r  <= count_nxt_s;
      sticky_r <= sticky_nxt_s;
      if (in_valid) begin
        data_r       <= data_nxt_s;
        z_r          <= res_z_s;
        contention_r <= contention_s;
      end
    end
  end

  assign out_valid         = valid_r;
  assign out_data          = data_r;
  assign out_z             = z_r;
  assign contention        = contention_r;
  assign contention_count  = count_r;
  assign sticky_contention = sticky_r;

endmodule

// File: tb/tb_net_resolver.sv
// Scoreboard bench: three resolver instances (WOR, WAND, TRI with charge hold) share
// driver inputs; each has its own in_valid, expected queue and monitor check.
module tb_net_resolver;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] z;
    logic       c;
    logic [7:0] cnt;
    logic       st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv_wor, iv_wand, iv_tri;
  logic [2:0]  drv_en;
  logic [23:0] drv_data;
  logic        clear_stats;

  logic       ov_wor, ov_wand, ov_tri;
  logic [7:0] od_wor, od_wand, od_tri;
  logic [7:0] oz_wor, oz_wand, oz_tri;
  logic       oc_wor, oc_wand, oc_tri;
  logic [7:0] cnt_wor, cnt_wand, cnt_tri;
  logic       st_wor, st_wand, st_tri;

  exp_t q_wor[$];
  exp_t q_wand[$];
  exp_t q_tri[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  net_resolver #(.WIDTH(8), .NUM_DRIVERS(3), .MODE(1), .CHARGE_HOLD(0), .CNT_W(8)) u_wor (
    .clk(clk), .rst(rst), .in_valid(iv_wor), .drv_en(drv_en), .drv_data(drv_data),
    .clear_stats(clear_stats), .out_valid(ov_wor), .out_data(od_wor), .out_z(oz_wor),
    .contention(oc_wor), .contention_count(cnt_wor), .sticky_contention(st_wor));

  net_resolver #(.WIDTH(8), .NUM_DRIVERS(3), .MODE(2), .CHARGE_HOLD(0), .CNT_W(8)) u_wand (
    .clk(clk), .rst(rst), .in_valid(iv_wand), .drv_en(drv_en), .drv_data(drv_data),
    .clear_stats(clear_stats), .out_valid(ov_wand), .out_data(od_wand), .out_z(oz_wand),
    .contention(oc_wand), .contention_count(cnt_wand), .sticky_contention(st_wand));

  net_resolver #(.WIDTH(8), .NUM_DRIVERS(3), .MODE(0), .CHARGE_HOLD(1), .CNT_W(8)) u_tri (
    .clk(clk), .rst(rst), .in_valid(iv_tri), .drv_en(drv_en), .drv_data(drv_data),
    .clear_stats(clear_stats), .out_valid(ov_tri), .out_data(od_tri), .out_z(oz_tri),
    .contention(oc_tri), .contention_count(cnt_tri), .sticky_contention(st_tri));

  function automatic exp_t mk(input logic [7:0] d, input logic [7:0] z, input logic c,
                              input logic [7:0] cnt, input logic st);
    exp_t e;
    e.d = d; e.z = z; e.c = c; e.cnt = cnt; e.st = st;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e, input logic [7:0] d,
                         input logic [7:0] z, input logic c, input logic [7:0] cnt,
                         input logic st);
    chk({tag, "_data"}, 32'(d), 32'(e.d));
    chk({tag, "_z"}, 32'(z), 32'(e.z));
    chk({tag, "_contention"}, 32'(c), 32'(e.c));
    chk({tag, "_count"}, 32'(cnt), 32'(e.cnt));
    chk({tag, "_sticky"}, 32'(st), 32'(e.st));
  endtask

  task automatic chk_idle_tri(input string tag, input exp_t e);
    chk({tag, "_valid"}, 32'(ov_tri), 32'd0);
    cmp_all(tag, e, od_tri, oz_tri, oc_tri, cnt_tri, st_tri);
  endtask

  // Monitor: every presented result must match the oldest expected entry.
  always @(negedge clk) begin
    if (ov_wor) begin
      if (q_wor.size() == 0) begin
        total++; bad++;
        $display("FAIL wor_unexpected_valid: got valid expected none");
      end else cmp_all("wor", q_wor.pop_front(), od_wor, oz_wor, oc_wor, cnt_wor, st_wor);
    end
    if (ov_wand) begin
      if (q_wand.size() == 0) begin
        total++; bad++;
        $display("FAIL wand_unexpected_valid: got valid expected none");
      end else cmp_all("wand", q_wand.pop_front(), od_wand, oz_wand, oc_wand, cnt_wand, st_wand);
    end
    if (ov_tri) begin
      if (q_tri.size() == 0) begin
        total++; bad++;
        $display("FAIL tri_unexpected_valid: got valid expected none");
      end else cmp_all("tri", q_tri.pop_front(), od_tri, oz_tri, oc_tri, cnt_tri, st_tri);
    end
  end

  // tgt: 0 = WOR, 1 = WAND, 2 = TRI
  task automatic drive(input int tgt, input logic [2:0] en, input logic [23:0] data,
                       input logic clr, input exp_t e);
    @(negedge clk);
    drv_en      = en;
    drv_data    = data;
    clear_stats = clr;
    iv_wor      = (tgt == 0);
    iv_wand     = (tgt == 1);
    iv_tri      = (tgt == 2);
    if (tgt == 0) q_wor.push_back(e);
    else if (tgt == 1) q_wand.push_back(e);
    else q_tri.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iv_wor = 1'b0; iv_wand = 1'b0; iv_tri = 1'b0; clear_stats = 1'b0;
    end
  endtask

  initial begin
    exp_t rst_e;
    rst_e = mk(8'h00, 8'hFF, 1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    iv_wor = 1'b0; iv_wand = 1'b0; iv_tri = 1'b0;
    drv_en = 3'b000; drv_data = 24'h000000; clear_stats = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_tri("reset_tri", rst_e);
    chk("reset_wor_valid", 32'(ov_wor), 32'd0);
    cmp_all("reset_wand", rst_e, od_wand, oz_wand, oc_wand, cnt_wand, st_wand);
    rst = 1'b0;

    // WOR
    drive(0, 3'b111, {8'h04, 8'h02, 8'h01}, 1'b0, mk(8'h07, 8'h00, 1'b0, 8'd0, 1'b0));
    drive(0, 3'b000, {8'hFF, 8'hFF, 8'hFF}, 1'b0, mk(8'h00, 8'hFF, 1'b0, 8'd0, 1'b0));
    drive(0, 3'b101, {8'h81, 8'hFF, 8'h10}, 1'b0, mk(8'h91, 8'h00, 1'b0, 8'd0, 1'b0));
    idle(2);
    // WAND
    drive(1, 3'b011, {8'hAA, 8'hF0, 8'h3C}, 1'b0, mk(8'h30, 8'h00, 1'b0, 8'd0, 1'b0));
    drive(1, 3'b000, {8'hFF, 8'hFF, 8'hFF}, 1'b0, mk(8'h00, 8'hFF, 1'b0, 8'd0, 1'b0));
    drive(1, 3'b111, {8'hFF, 8'h0F, 8'h3C}, 1'b0, mk(8'h0C, 8'h00, 1'b0, 8'd0, 1'b0));
    idle(2);
    // TRI with charge hold
    drive(2, 3'b001, {8'h00, 8'h00, 8'hA5}, 1'b0, mk(8'hA5, 8'h00, 1'b0, 8'd0, 1'b0));
    drive(2, 3'b000, {8'h00, 8'h00, 8'h00}, 1'b0, mk(8'hA5, 8'hFF, 1'b0, 8'd0, 1'b0));
    drive(2, 3'b110, {8'hC3, 8'hC3, 8'h00}, 1'b0, mk(8'hC3, 8'h00, 1'b0, 8'd0, 1'b0));
    drive(2, 3'b000, {8'h00, 8'h00, 8'h00}, 1'b0, mk(8'hC3, 8'hFF, 1'b0, 8'd0, 1'b0));
    // Back-to-back contention, counter saturates at 255
    for (int k = 1; k <= 300; k++) begin
      drive(2, 3'b011, {8'h00, 8'h0F, 8'h0E}, 1'b0,
            mk(8'h0F, 8'h00, 1'b1, (k > 255) ? 8'd255 : 8'(k), 1'b1));
    end
    // Clear together with a contending sample counts that sample
    drive(2, 3'b011, {8'h00, 8'h0F, 8'h0E}, 1'b1, mk(8'h0F, 8'h00, 1'b1, 8'd1, 1'b1));
    @(negedge clk);
    iv_tri = 1'b0; clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk_idle_tri("idle_clear", mk(8'h0F, 8'h00, 1'b1, 8'd0, 1'b0));
    drive(2, 3'b001, {8'hFF, 8'hFF, 8'h33}, 1'b0, mk(8'h33, 8'h00, 1'b0, 8'd0, 1'b0));
    idle(2);
    // Reset coinciding with a sample: no result may follow
    @(negedge clk);
    rst = 1'b1; iv_tri = 1'b1; drv_en = 3'b001; drv_data = {8'h00, 8'h00, 8'h5A};
    @(negedge clk);
    rst = 1'b0; iv_tri = 1'b0;
    chk_idle_tri("after_rst", rst_e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_idle_tri("rst_hold", rst_e);
    end
    idle(2);
    chk("wor_pending", 32'(q_wor.size()), 32'd0);
    chk("wand_pending", 32'(q_wand.size()), 32'd0);
    chk("tri_pending", 32'(q_tri.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
